// File: rtl/beat_pulse_qualifier.sv
// Heartbeat front end: sync, debounce, edge detect and refractory gating.
// Emits one-cycle beat strobes plus beat interval and missing-beat timeout.
module beat_pulse_qualifier #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int REFRACTORY_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES    = 5000,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_in,
  input  logic             enb_in,
  output logic             beat,
  output logic             beat_level,
  output logic [CNT_W-1:0] interval,
  output logic             interval_valid,
  output logic             timeout
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RF_W = $clog2(REFRACTORY_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RF_W-1:0]  RF_LAST = RF_W'(REFRACTORY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ARMED,
    REFRACT,
    WAIT_LOW
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;

  logic [DB_W-1:0]  db_q, db_d;
  logic             lvl_q, lvl_d;
  state_e           state_q, state_d;
  logic [RF_W-1:0]  rf_q, rf_d;
  logic [CNT_W-1:0] since_q, since_d;
  logic [CNT_W-1:0] since_inc;
  logic             first_q, first_d;
  logic [CNT_W-1:0] intv_q, intv_d;
  logic             beat_q, beat_d;
  logic             ivld_q, ivld_d;
  logic             rise;

  assign sync_bit  = sync_q[SYNC_STAGES-1];
  assign since_inc = (since_q == '1) ? since_q
                                     : since_q + CNT_W'(1);

  // Synchroniser keeps running while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_in};
    end
  end

  always_comb begin
    db_d    = db_q;
    lvl_d   = lvl_q;
    state_d = state_q;
    rf_d    = rf_q;
    since_d = since_q;
    first_d = first_q;
    intv_d  = intv_q;
    beat_d  = 1'b0;
    ivld_d  = 1'b0;
    rise    = 1'b0;
    if (enb_in) begin
      if (sync_bit != lvl_q) begin
        if (db_q == DB_LAST) begin
          lvl_d = ~lvl_q;
          db_d  = '0;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end else begin
        db_d = '0;
      end
      rise    = ~lvl_q & lvl_d;
      since_d = since_inc;
      unique case (state_q)
        ARMED: begin
          if (rise) begin
            beat_d  = 1'b1;
            state_d = REFRACT;
            rf_d    = '0;
          end
        end
        REFRACT: begin
          if (rf_q == RF_LAST) begin
            state_d = lvl_q ? WAIT_LOW : ARMED;
          end else begin
            rf_d = rf_q + RF_W'(1);
          end
        end
        WAIT_LOW: begin
          if (!lvl_q) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
      // First beat after reset only arms the interval measurement.
      if (beat_d) begin
        since_d = '0;
        first_d = 1'b1;
        if (first_q) begin
          intv_d = since_inc;
          ivld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q    <= '0;
      lvl_q   <= 1'b0;
      state_q <= ARMED;
      rf_q    <= '0;
      since_q <= '0;
      first_q <= 1'b0;
      intv_q  <= '0;
      beat_q  <= 1'b0;
      ivld_q  <= 1'b0;
    end else begin
      db_q    <= db_d;
      lvl_q   <= lvl_d;
      state_q <= state_d;
      rf_q    <= rf_d;
      since_q <= since_d;
      first_q <= first_d;
      intv_q  <= intv_d;
      beat_q  <= beat_d;
      ivld_q  <= ivld_d;
    end
  end

  assign beat           = beat_q;
  assign beat_level     = lvl_q;
  assign interval       = intv_q;
  assign interval_valid = ivld_q;
  assign timeout        = (since_q >= TMO);

endmodule
